// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult_arb_pkg;

  localparam int OP_W   = 4;   // operand width
  localparam int PROD_W = 8;   // full unsigned product width
  localparam int CNT_W  = 8;   // completed-transaction counter width
  localparam int ID_W   = 2;   // requester index width (up to 4 requesters)

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// multiplier_c: registered unsigned 4x4 multiplier shared by all requesters.
// Latency: product valid the cycle after start; holds until the next start.
// Backpressure: none; the arbiter FSM only pulses start when it owns the result.
// Ports: clk, n_rst (sync, active-low), start, a, b -> product.
module multiplier_c
  import mult_arb_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] product
);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      product <= '0;
    end else if (start) begin
      product <= PROD_W'(a) * PROD_W'(b);
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter granting NREQ requesters access to one shared multiplier.
// Latency: accept in cycle 0, rsp_valid in cycle 3; one transaction every 4+ cycles.
// Backpressure: response held stable in RESP until rsp_ready; no new grant meanwhile.
// Ports: req_valid/req_m1/req_m2 -> req_ready (one-hot accept); rsp_valid/rsp_id/
//        rsp_product <- rsp_ready; busy (not IDLE); op_count (completed, wraps).
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_m1,
  input  logic [4*NREQ-1:0] req_m2,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [1:0]        rsp_id,
  output logic [7:0]        rsp_product,
  input  logic              rsp_ready,
  output logic              busy,
  output logic [7:0]        op_count
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);
  localparam logic [ID_W:0]   NREQ_W  = (ID_W + 1)'(NREQ);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_q;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic [NREQ-1:0]   rotated;
  logic [ID_W:0]     sum;
  logic [OP_W-1:0]   m1_q, m2_q;
  logic [PROD_W-1:0] product;
  logic              start;
  logic              accept;
  logic              done;

  // Rotate so bit 0 is the requester at rr_ptr; the first set bit is the winner.
  assign rotated = NREQ'({req_valid, req_valid} >> rr_ptr);

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && rotated[k]) begin
        grant_found = 1'b1;
        sum         = {1'b0, rr_ptr} + (ID_W + 1)'(k);
        grant_idx   = (sum >= NREQ_W) ? ID_W'(sum - NREQ_W) : ID_W'(sum);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (grant_found) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_WAIT;
      ST_WAIT: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. Response fields are zero outside RESP; the rsp_* path only
  // sees registered state, never req_valid.
  always_comb begin
    req_ready   = '0;
    accept      = 1'b0;
    start       = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    rsp_valid   = 1'b0;
    rsp_id      = '0;
    rsp_product = '0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        // Gated by n_rst so no accept strobe is shown while reset is held.
        if (grant_found && n_rst) begin
          accept    = 1'b1;
          req_ready = NREQ'(1) << grant_idx;
        end
      end
      ST_LOAD: start = 1'b1;
      ST_WAIT: start = 1'b0;
      ST_RESP: begin
        rsp_valid   = 1'b1;
        rsp_id      = grant_q;
        rsp_product = product;
        done        = rsp_ready;
      end
      default: busy = 1'b0;
    endcase
  end

  // Operand/grant latches, round-robin pointer, completion counter
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rr_ptr   <= '0;
      grant_q  <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      op_count <= '0;
    end else begin
      if (accept) begin
        grant_q <= grant_idx;
        m1_q    <= OP_W'(req_m1 >> {grant_idx, 2'b00});
        m2_q    <= OP_W'(req_m2 >> {grant_idx, 2'b00});
      end
      if (done) begin
        rr_ptr   <= (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
        op_count <= op_count + 8'd1;
      end
    end
  end

  multiplier_c u_mult (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .a       (m1_q),
    .b       (m2_q),
    .product (product)
  );

endmodule

// File: doc/mult_share_arbiter.md
MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 Parameter: NREQ, default 2, number of requesters; legal range 2..4.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: n_rst  in  1  reset, synchronous, active-low.
REQ-004 Port: req_valid  in  NREQ  per-requester operation request.
REQ-005 Port: req_m1  in  4*NREQ  packed multipliers; requester i at bits [4i+3:4i].
REQ-006 Port: req_m2  in  4*NREQ  packed multiplicands, same packing.
REQ-007 Port: req_ready  out  NREQ  one-hot accept strobe.
REQ-008 Port: rsp_valid  out  1  result available.
REQ-009 Port: rsp_id  out  2  index of the requester owning the result.
REQ-010 Port: rsp_product  out  8  unsigned 4x4 product.
REQ-011 Port: rsp_ready  in  1  result consumer ready.
REQ-012 Port: busy  out  1  high in every state except IDLE.
REQ-013 Port: op_count  out  8  completed-transaction counter.

Function
REQ-014 States: IDLE, LOAD, WAIT, RESP; encoding defined in the shared package.
REQ-015 IDLE: if any req_valid is high, grant the first set requester at or after rr_ptr (cyclic order); req_ready[grant] = 1 for that cycle only; latch operands and grant index; next state LOAD.
REQ-016 IDLE with no req_valid: req_ready = 0; remain in IDLE.
REQ-017 At most one req_ready bit shall be high in any cycle; req_ready = 0 outside IDLE.
REQ-018 LOAD: drive the multiplier's start = 1 with the latched operands; next state WAIT.
REQ-019 WAIT: start = 0; unconditionally advance to RESP.
REQ-020 RESP: rsp_valid = 1; rsp_product = multiplier product; rsp_id = latched grant.
REQ-021 RESP: rsp_valid, rsp_id and rsp_product hold stable until rsp_ready = 1.
REQ-022 On the RESP cycle where rsp_ready = 1:
- next state IDLE;
- rr_ptr <= (grant+1) mod NREQ;
- op_count increments by 1, wrapping 255 -> 0.
REQ-023 Latency: accept in cycle 0 -> rsp_valid first high in cycle 3; minimum issue interval 4 cycles.
REQ-024 rsp_ready high outside RESP shall have no effect.
REQ-025 req_valid changes outside IDLE shall have no effect; an accepted transaction completes regardless of its requester.
REQ-026 Arithmetic: rsp_product = m1*m2, unsigned, full 8 bits, no truncation (15*15 = 225).

Reset
REQ-027 n_rst = 0 at a rising edge shall force:
- state IDLE, rr_ptr 0, op_count 0;
- latched operands and grant 0.
REQ-028 Outputs during and immediately after reset:
- req_ready 0, rsp_valid 0, rsp_id 0, rsp_product 0, busy 0.
REQ-029 Reset in any non-IDLE state shall discard the in-flight transaction; no response is issued for it.

Structure
REQ-030 Package mult_arb_pkg shall hold:
- state typedef/encoding;
- operand width 4, product width 8, counter width 8.
REQ-031 Exactly one sub-module: multiplier_c, instantiated once as the shared datapath.
- clk and n_rst connected directly;
- start from the FSM;
- operands from the latch registers.
REQ-032 No combinational path from req_valid to rsp_* outputs.

Verification
REQ-033 Single request: requester 0, m1 = 3, m2 = 5 -> req_ready[0] pulses in cycle 0; rsp_valid in cycle 3 with product 15, id 0.
REQ-034 Contention: both requesters hold valid (0: 15x15, 1: 2x7), rsp_ready = 1 -> responses in order id0 = 225, id1 = 14, issued 4 cycles apart.
REQ-035 Backpressure: rsp_ready held low 5 cycles in RESP -> rsp_* held stable; no new req_ready until after the handshake.
REQ-036 Reset mid-operation: n_rst low in WAIT -> next cycle all outputs 0, state IDLE, no rsp_valid for the aborted operation.
REQ-037 Counter wrap: 256 completed transactions -> op_count returns to 0; zero operands (0x9) -> product 0.
